// File: rtl/vga_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_buffer_if
// Description : Request/response bundle for the VGA frame buffer. Carries the
//               pixel write port, the pixel read port and the frame-fill
//               control/status signals.
//               master : drives i* requests, observes o* responses
//               slave  : the frame buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_buffer_if #(
    parameter int DATA_WIDTH = 3,
    parameter int COORD_BITS = 10
);
    // Write port
    logic                  iWriteEnable;
    logic [COORD_BITS-1:0] iWriteX;
    logic [COORD_BITS-1:0] iWriteY;
    logic [DATA_WIDTH-1:0] iDataIn;
    // Read port
    logic                  iReadEnable;
    logic [COORD_BITS-1:0] iReadX;
    logic [COORD_BITS-1:0] iReadY;
    logic [DATA_WIDTH-1:0] oDataOut;
    logic                  oReadValid;
    // Frame fill
    logic                  iClearStart;
    logic [DATA_WIDTH-1:0] iClearColor;
    logic                  oClearBusy;
    logic                  oClearDone;
    // Status
    logic                  oWriteDropped;

    modport master (
        output iWriteEnable, iWriteX, iWriteY, iDataIn,
        output iReadEnable, iReadX, iReadY,
        output iClearStart, iClearColor,
        input  oDataOut, oReadValid, oClearBusy, oClearDone, oWriteDropped
    );

    modport slave (
        input  iWriteEnable, iWriteX, iWriteY, iDataIn,
        input  iReadEnable, iReadX, iReadY,
        input  iClearStart, iClearColor,
        output oDataOut, oReadValid, oClearBusy, oClearDone, oWriteDropped
    );
endinterface
`default_nettype wire

// File: rtl/vga_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_buffer
// Description : Single-clock WIDTH_SIZE x HEIGHT_SIZE pixel store with one
//               write port, one registered read port (latency 1, read-first)
//               and a frame-fill engine that writes one word per cycle.
// Ports       : Clock - rising-edge clock
//               Reset - asynchronous, active-low reset
//               bus   - vga_frame_buffer_if.slave (write / read / fill / status)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_buffer #(
    parameter int DATA_WIDTH  = 3,
    parameter int WIDTH_SIZE  = 640,
    parameter int HEIGHT_SIZE = 480,
    parameter int COORD_BITS  = 10
) (
    input wire logic          Clock,
    input wire logic          Reset,
    vga_frame_buffer_if.slave bus
);

    localparam int c_DEPTH     = WIDTH_SIZE * HEIGHT_SIZE;
    localparam int c_ADDR_BITS = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    // Wide enough that Y*WIDTH_SIZE+X can never overflow for any coordinate.
    localparam int c_LIN_BITS  = COORD_BITS + $clog2(WIDTH_SIZE + 1) + 1;

    localparam logic [c_LIN_BITS-1:0]  c_WIDTH_LIN = c_LIN_BITS'(WIDTH_SIZE);
    localparam logic [31:0]            c_WIDTH_32  = 32'(WIDTH_SIZE);
    localparam logic [31:0]            c_HEIGHT_32 = 32'(HEIGHT_SIZE);
    localparam logic [c_ADDR_BITS-1:0] c_LAST_ADDR = c_ADDR_BITS'(c_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_ADDR_BITS-1:0]  r_fill_cnt;
    logic [DATA_WIDTH-1:0]   r_clear_color;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_read_valid;
    logic                    r_write_dropped;

    logic [DATA_WIDTH-1:0]   r_mem [0:c_DEPTH-1];

    logic                    w_busy;
    logic                    w_done;
    logic                    w_fill_we;
    logic                    w_wr_in;
    logic                    w_rd_in;
    logic [c_LIN_BITS-1:0]   w_wr_lin;
    logic [c_LIN_BITS-1:0]   w_rd_lin;
    logic [c_ADDR_BITS-1:0]  w_wr_addr;
    logic [c_ADDR_BITS-1:0]  w_rd_addr;
    logic                    w_mem_we;
    logic [c_ADDR_BITS-1:0]  w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    // ------------------------------------------------------------------
    // Coordinate decode. Range checks are done on the raw coordinates, so
    // the narrowed address is only ever used when it is below c_DEPTH.
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_in   = (32'(bus.iWriteX) < c_WIDTH_32) && (32'(bus.iWriteY) < c_HEIGHT_32);
        w_rd_in   = (32'(bus.iReadX)  < c_WIDTH_32) && (32'(bus.iReadY)  < c_HEIGHT_32);
        w_wr_lin  = c_LIN_BITS'(bus.iWriteY) * c_WIDTH_LIN + c_LIN_BITS'(bus.iWriteX);
        w_rd_lin  = c_LIN_BITS'(bus.iReadY)  * c_WIDTH_LIN + c_LIN_BITS'(bus.iReadX);
        w_wr_addr = c_ADDR_BITS'(w_wr_lin);
        w_rd_addr = c_ADDR_BITS'(w_rd_lin);
    end

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_fill_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.iClearStart) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                w_busy    = 1'b1;
                w_fill_we = 1'b1;
                if (r_fill_cnt == c_LAST_ADDR) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Fill counter and latched fill colour
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_fill_cnt    <= '0;
            r_clear_color <= '0;
        end else if (r_state == IDLE) begin
            if (bus.iClearStart) begin
                r_fill_cnt    <= '0;
                r_clear_color <= bus.iClearColor;
            end
        end else if (r_state == CLEAR && r_fill_cnt != c_LAST_ADDR) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Single memory write port: the fill engine owns it while busy; an
    // external write in the IDLE cycle that starts a fill still lands,
    // and the fill overwrites it later.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_we    = w_fill_we | (bus.iWriteEnable & ~w_busy & w_wr_in);
        w_mem_addr  = w_fill_we ? r_fill_cnt    : w_wr_addr;
        w_mem_wdata = w_fill_we ? r_clear_color : bus.iDataIn;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge Clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read port. Non-blocking update of r_mem makes a same-cycle
    // read of the written address return the old word.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_data_out   <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= bus.iReadEnable;
            if (bus.iReadEnable) begin
                r_data_out <= w_rd_in ? r_mem[w_rd_addr] : '0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_write_dropped <= 1'b0;
        end else begin
            r_write_dropped <= bus.iWriteEnable & (w_busy | ~w_wr_in);
        end
    end

    assign bus.oDataOut      = r_data_out;
    assign bus.oReadValid    = r_read_valid;
    assign bus.oClearBusy    = w_busy;
    assign bus.oClearDone    = w_done;
    assign bus.oWriteDropped = r_write_dropped;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_frame_buffer
// Description : Self-checking bench for vga_frame_buffer (8x4, 3-bit pixels).
//               A behavioural model (array + fill start time) predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_buffer;

    localparam int DW = 3;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CB = 10;
    localparam int N  = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_buffer_if #(.DATA_WIDTH(DW), .COORD_BITS(CB)) bus ();

    vga_frame_buffer #(
        .DATA_WIDTH (DW),
        .WIDTH_SIZE (W),
        .HEIGHT_SIZE(H),
        .COORD_BITS (CB)
    ) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model
    logic [DW-1:0] m_mem   [N];
    bit            m_known [N];
    bit            m_fill_on  = 1'b0;
    int            m_edges    = 0;
    int            m_fill_start = 0;
    logic [DW-1:0] m_color    = '0;
    bit            e_valid    = 1'b0;
    logic [DW-1:0] e_data     = '0;
    bit            e_known    = 1'b1;
    bit            e_dropped  = 1'b0;
    bit            e_busy     = 1'b0;
    bit            e_done     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    task automatic idle();
        bus.iWriteEnable = 1'b0;
        bus.iWriteX      = '0;
        bus.iWriteY      = '0;
        bus.iDataIn      = '0;
        bus.iReadEnable  = 1'b0;
        bus.iReadX       = '0;
        bus.iReadY       = '0;
        bus.iClearStart  = 1'b0;
        bus.iClearColor  = '0;
    endtask

    task automatic wr(input int x, input int y, input int d);
        bus.iWriteEnable = 1'b1;
        bus.iWriteX      = CB'(x);
        bus.iWriteY      = CB'(y);
        bus.iDataIn      = DW'(d);
    endtask

    task automatic rd(input int x, input int y);
        bus.iReadEnable = 1'b1;
        bus.iReadX      = CB'(x);
        bus.iReadY      = CB'(y);
    endtask

    // Advance one clock: predict from the inputs, then compare all outputs.
    task automatic step();
        int  wx, wy, rx, ry, p;
        bit  busy_now;
        wx = int'(bus.iWriteX);
        wy = int'(bus.iWriteY);
        rx = int'(bus.iReadX);
        ry = int'(bus.iReadY);
        p  = m_edges - m_fill_start;
        busy_now = m_fill_on;

        if (bus.iReadEnable) begin
            e_valid = 1'b1;
            if (in_range(rx, ry)) begin
                e_data  = m_mem[ry * W + rx];
                e_known = m_known[ry * W + rx];
            end else begin
                e_data  = '0;
                e_known = 1'b1;
            end
        end else begin
            e_valid = 1'b0;
        end

        e_dropped = bus.iWriteEnable && (busy_now || !in_range(wx, wy));

        if (busy_now && p < N) begin
            m_mem[p]   = m_color;
            m_known[p] = 1'b1;
        end else if (!busy_now && bus.iWriteEnable && in_range(wx, wy)) begin
            m_mem[wy * W + wx]   = bus.iDataIn;
            m_known[wy * W + wx] = 1'b1;
        end

        if (!busy_now && bus.iClearStart) begin
            m_fill_on    = 1'b1;
            m_fill_start = m_edges + 1;
            m_color      = bus.iClearColor;
        end

        m_edges++;
        if (m_fill_on && (m_edges - m_fill_start) > N) m_fill_on = 1'b0;
        e_busy = m_fill_on;
        e_done = m_fill_on && ((m_edges - m_fill_start) == N);

        @(posedge clk);
        #1;
        chk("read_valid", int'(bus.oReadValid), int'(e_valid));
        if (e_known) chk("read_data", int'(bus.oDataOut), int'(e_data));
        chk("clear_busy", int'(bus.oClearBusy), int'(e_busy));
        chk("clear_done", int'(bus.oClearDone), int'(e_done));
        chk("write_dropped", int'(bus.oWriteDropped), int'(e_dropped));
    endtask

    // Asserts reset mid-cycle and checks outputs clear without a clock edge.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        m_fill_on = 1'b0;
        for (int i = 0; i < N; i++) m_known[i] = 1'b0;
        e_valid = 1'b0; e_data = '0; e_known = 1'b1;
        e_dropped = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        chk("rst_valid", int'(bus.oReadValid), 0);
        chk("rst_data", int'(bus.oDataOut), 0);
        chk("rst_busy", int'(bus.oClearBusy), 0);
        chk("rst_done", int'(bus.oClearDone), 0);
        chk("rst_dropped", int'(bus.oWriteDropped), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Starts a fill and runs it to completion, checking its duration.
    task automatic run_fill(input int color);
        int busy_cnt, done_at, done_pulses, guard;
        idle();
        bus.iClearStart = 1'b1;
        bus.iClearColor = DW'(color);
        step();
        idle();
        busy_cnt    = bus.oClearBusy ? 1 : 0;
        done_at     = 0;
        done_pulses = 0;
        guard       = 0;
        while (bus.oClearBusy && guard < 100) begin
            step();
            guard++;
            if (bus.oClearBusy) busy_cnt++;
            if (bus.oClearDone) begin
                done_pulses++;
                if (done_at == 0) done_at = busy_cnt;
            end
        end
        chk("fill_busy_cycles", busy_cnt, N + 1);
        chk("fill_done_cycle", done_at, N + 1);
        chk("fill_done_pulses", done_pulses, 1);
    endtask

    initial begin
        int drops;
        idle();
        do_reset();

        // Fill with 6, then read every pixel
        run_fill(6);
        for (int a = 0; a < N; a++) begin
            idle(); rd(a % W, a / W); step();
            chk("fill6_read", int'(bus.oDataOut), 6);
        end

        // Write (3,2)=5, read it back one cycle later, then hold
        idle(); wr(3, 2, 5); step();
        idle(); rd(3, 2); step();
        chk("rd32_data", int'(bus.oDataOut), 5);
        chk("rd32_valid", int'(bus.oReadValid), 1);
        idle(); step();
        chk("hold_valid", int'(bus.oReadValid), 0);
        chk("hold_data", int'(bus.oDataOut), 5);

        // Out-of-range writes are dropped
        drops = 0;
        idle(); wr(8, 0, 7); step(); drops += int'(bus.oWriteDropped);
        idle(); wr(0, 4, 7); step(); drops += int'(bus.oWriteDropped);
        idle(); step();               drops += int'(bus.oWriteDropped);
        chk("oor_drop_pulses", drops, 2);
        idle(); rd(0, 0); step();
        chk("rd00_unchanged", int'(bus.oDataOut), 6);

        // Out-of-range read returns zero with valid
        idle(); rd(9, 1); step();
        chk("oor_read_data", int'(bus.oDataOut), 0);
        chk("oor_read_valid", int'(bus.oReadValid), 1);

        // Read-first on a same-cycle read/write
        idle(); wr(2, 2, 1); step();
        idle(); wr(2, 2, 4); rd(2, 2); step();
        chk("rdw_old", int'(bus.oDataOut), 1);
        idle(); rd(2, 2); step();
        chk("rdw_new", int'(bus.oDataOut), 4);

        // Write in the fill-start cycle lands before the fill reaches it
        idle(); wr(5, 3, 1); bus.iClearStart = 1'b1; bus.iClearColor = 3'd2; step();
        idle(); rd(5, 3); step();
        chk("start_write_lands", int'(bus.oDataOut), 1);
        for (int g = 0; g < 100 && bus.oClearBusy; g++) begin idle(); step(); end
        idle(); rd(5, 3); step();
        chk("start_write_overwritten", int'(bus.oDataOut), 2);

        // Write during a fill is dropped, pixel gets fill colour
        idle(); bus.iClearStart = 1'b1; bus.iClearColor = 3'd3; step();
        idle(); step(); step();
        wr(1, 1, 2); step();
        chk("fill_write_dropped", int'(bus.oWriteDropped), 1);
        for (int g = 0; g < 100 && bus.oClearBusy; g++) begin idle(); step(); end
        idle(); rd(1, 1); step();
        chk("rd11_fill_color", int'(bus.oDataOut), 3);

        // Reset on fill cycle 10, then a clean fill
        idle(); bus.iClearStart = 1'b1; bus.iClearColor = 3'd5; step();
        idle();
        for (int i = 0; i < 9; i++) step();
        chk("busy_before_reset", int'(bus.oClearBusy), 1);
        #2;
        do_reset();
        chk("idle_after_reset", int'(bus.oClearBusy), 0);
        run_fill(1);
        for (int a = 0; a < N; a += 7) begin
            idle(); rd(a % W, a / W); step();
            chk("refill_read", int'(bus.oDataOut), 1);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                wr(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1)
                rd(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)));
            if ($urandom_range(0, 59) == 0) begin
                bus.iClearStart = 1'b1;
                bus.iClearColor = DW'($urandom_range(0, 7));
            end
            step();
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_frame_buffer.md
VGA_FRAME_BUFFER -- requirements
Module: vga_frame_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 3, meaning the pixel width in bits.
REQ-002 The block SHALL have parameter WIDTH_SIZE, default 640, meaning the pixels per line.
REQ-003 The block SHALL have parameter HEIGHT_SIZE, default 480, meaning the lines per frame.
REQ-004 The block SHALL have parameter COORD_BITS, default 10, meaning the width of each X/Y coordinate port.
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port iWriteEnable, input, 1 bit: a pixel write request.
REQ-008 The block SHALL have ports iWriteX and iWriteY, input, COORD_BITS each: the write pixel column and row.
REQ-009 The block SHALL have port iDataIn, input, DATA_WIDTH: the write pixel value.
REQ-010 The block SHALL have port iReadEnable, input, 1 bit: a pixel read request.
REQ-011 The block SHALL have ports iReadX and iReadY, input, COORD_BITS each: the read pixel column and row.
REQ-012 The block SHALL have port oDataOut, output, DATA_WIDTH: the registered read data.
REQ-013 The block SHALL have port oReadValid, output, 1 bit: qualifies oDataOut.
REQ-014 The block SHALL have port iClearStart, input, 1 bit: a one-cycle request to fill the frame.
REQ-015 The block SHALL have port iClearColor, input, DATA_WIDTH: the fill value, sampled with iClearStart.
REQ-016 The block SHALL have port oClearBusy, output, 1 bit: high while a fill is in progress.
REQ-017 The block SHALL have port oClearDone, output, 1 bit: a one-cycle pulse at fill completion.
REQ-018 The block SHALL have port oWriteDropped, output, 1 bit: a one-cycle pulse when a write request is discarded.

Function
REQ-019 Storage SHALL be WIDTH_SIZE*HEIGHT_SIZE words of DATA_WIDTH bits; the linear address is Y*WIDTH_SIZE+X, computed at full precision with no truncation.
REQ-020 A write with X<WIDTH_SIZE and Y<HEIGHT_SIZE, while not busy, SHALL update memory at that clock edge.
REQ-021 A write with X>=WIDTH_SIZE or Y>=HEIGHT_SIZE SHALL NOT modify memory and SHALL pulse oWriteDropped the next cycle.
REQ-022 A read SHALL have a latency of 1: oDataOut and oReadValid SHALL be valid the cycle after iReadEnable is sampled.
REQ-023 When iReadEnable is low, oReadValid SHALL be 0 and oDataOut SHALL hold its last value.
REQ-024 An out-of-range read SHALL return all-zeros with oReadValid=1.
REQ-025 A read and a write to the same address in the same cycle SHALL return the old data (read-first).
REQ-026 The fill FSM SHALL have states IDLE, CLEAR and DONE; the reset state is IDLE.
REQ-027 In IDLE, iClearStart=1 SHALL latch iClearColor, zero the fill counter and move to CLEAR.
REQ-028 In CLEAR, one word per cycle SHALL be written at the counter address with the latched color, and the counter SHALL increment.
REQ-029 After address N-1 (N=WIDTH_SIZE*HEIGHT_SIZE) is written, the FSM SHALL move to DONE; the fill takes exactly N cycles in CLEAR.
REQ-030 In DONE, oClearDone SHALL be 1 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-031 oClearBusy SHALL be 1 in CLEAR and DONE and 0 in IDLE; iClearStart while busy SHALL be ignored.
REQ-032 While busy, external writes SHALL be discarded and SHALL pulse oWriteDropped; the fill has priority.
REQ-033 Reads SHALL remain serviced during a fill with the same 1-cycle latency.
REQ-034 iClearStart and iWriteEnable in the same IDLE cycle SHALL both take effect, with the write landing before the fill overwrites it.

Reset
REQ-035 On Reset=0, regardless of Clock, the following SHALL be forced: FSM=IDLE, fill counter=0, oDataOut=0, oReadValid=0, oClearBusy=0, oClearDone=0, oWriteDropped=0.
REQ-036 Memory contents SHALL NOT be reset, and SHALL be undefined after power-up or after a reset that interrupts a fill.
REQ-037 After Reset is released, the block SHALL accept requests on the first rising edge.

Verification (WIDTH_SIZE=8, HEIGHT_SIZE=4, DATA_WIDTH=3)
REQ-038 The bench SHALL cover: write (3,2)=5, then read (3,2) -> oDataOut=5, oReadValid=1, exactly 1 cycle after the read.
REQ-039 The bench SHALL cover: write (8,0)=7 and write (0,4)=7 -> oWriteDropped pulses twice, and a read of (0,0) is unchanged.
REQ-040 The bench SHALL cover: iClearStart with iClearColor=6 -> oClearBusy=1 for 33 cycles, oClearDone pulses on cycle 33, and all 32 reads return 6.
REQ-041 The bench SHALL cover: a write (1,1)=2 during a fill -> oWriteDropped=1, and (1,1) reads the fill color after done.
REQ-042 The bench SHALL cover: Reset asserted on fill cycle 10 -> oClearBusy=0 immediately, FSM=IDLE, and a new fill completes normally.
REQ-043 The bench SHALL cover: a simultaneous read and write of (2,2), old=1, new=4 -> read returns 1, and the next read returns 4.
